// File: rtl/cast_from_uint_stage.sv
// cast_from_uint_stage
// Casts a raw 7-bit UInt into a 7-bit enum encoding through a single
// registered pipeline stage. Illegal codes are counted (saturating),
// flagged sticky, optionally replaced by the default enum 7'h00, and can
// optionally halt the input side until a clear pulse.
//
// Handshake: a word moves across an interface only on a rising clock edge
// where valid && ready are both high. A producer holds valid and its data
// steady until that edge; ready may rise or fall freely, and valid never
// waits on ready. in_ready is derived from the stage's own state plus
// out_ready, so a full stage whose consumer is taking the word this cycle
// can accept a new word on the same edge (full throughput).
module cast_from_uint_stage #(
    parameter int SAFE_CAST     = 1,
    parameter int HALT_ON_ERROR = 0,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_bits,
    output logic             out_legal,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic             halted,
    input  logic             clear
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       in_legal;
    logic [6:0] cast_bits;
    logic       in_fire;
    logic       out_fire;
    logic       illegal_fire;

    // Legality decode of the raw word: exactly five encodings are valid.
    always_comb begin
        in_legal = 1'b0;
        case (in_bits)
            7'h00, 7'h01, 7'h02, 7'h64, 7'h65: in_legal = 1'b1;
            default:                           in_legal = 1'b0;
        endcase
    end

    // Illegal words either collapse to the default enum or pass raw.
    always_comb begin
        cast_bits = in_bits;
        if (!in_legal && (SAFE_CAST != 0)) begin
            cast_bits = 7'h00;
        end
    end

    assign in_ready     = (state_q == ST_RUN) && (!out_valid || out_ready);
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign illegal_fire = in_fire && !in_legal;
    assign halted       = (state_q == ST_HALTED);

    // State register for the RUN/HALTED machine.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt on an accepted illegal word if enabled; clear wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (illegal_fire && (HALT_ON_ERROR != 0)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (clear) begin
            state_d = ST_RUN;
        end
    end

    // Output register: load on accept, empty on drain, hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bits  <= 7'h00;
            out_legal <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_bits  <= cast_bits;
            out_legal <= in_legal;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Error bookkeeping: saturating count plus sticky flag; clear wins.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (illegal_fire) begin
            err_sticky <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/cast_from_uint_stage.md
CAST_FROM_UINT_STAGE -- requirements
Module: cast_from_uint_stage

Interface
REQ-001 Parameter SAFE_CAST, default 1; 1 = illegal raw codes are replaced by the default enum value 7'h00, 0 = raw bits pass through unchanged.
REQ-002 Parameter HALT_ON_ERROR, default 0; 1 = the block stops accepting input after the first illegal code.
REQ-003 Parameter CNT_W, default 8; width of the error counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  raw word present.
REQ-008 in_ready  output  1  block accepts the raw word this cycle.
REQ-009 in_bits  input  7  raw UInt to cast.
REQ-010 out_valid  output  1  enum result held in the output register.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_bits  output  7  enum encoding.
REQ-013 out_legal  output  1  registered in_bits was a legal encoding.
REQ-014 err_count  output  CNT_W  saturating count of illegal codes accepted.
REQ-015 err_sticky  output  1  set on the first illegal code accepted.
REQ-016 halted  output  1  block is in the HALTED state.
REQ-017 clear  input  1  single-cycle pulse; clears err_count, err_sticky and HALTED.

Function
REQ-018 The legal set SHALL be exactly {7'h00, 7'h01, 7'h02, 7'h64, 7'h65}; every other value is illegal.
REQ-019 Legality SHALL be decoded combinationally from in_bits; out_legal and out_bits SHALL be registered at the transfer (accept) edge.
REQ-020 An input transfer SHALL occur when in_valid && in_ready.
REQ-021 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready), giving full throughput with one cycle of latency from accept to out_valid.
REQ-022 An output transfer SHALL occur when out_valid && out_ready; out_valid SHALL deassert after it unless a new input is accepted in the same cycle.
REQ-023 While out_valid && !out_ready, out_bits and out_legal SHALL hold stable.
REQ-024 For a legal code, out_bits SHALL equal in_bits.
REQ-025 For an illegal code, out_bits SHALL be 7'h00 when SAFE_CAST=1 and in_bits when SAFE_CAST=0; out_legal SHALL be 0 in both cases.
REQ-026 Each accepted illegal code SHALL increment err_count by 1, saturating at all-ones, and SHALL set err_sticky.
REQ-027 The state machine SHALL have two states, RUN and HALTED; RUN->HALTED on an accepted illegal code only when HALT_ON_ERROR=1; HALTED->RUN on clear.
REQ-028 In HALTED, in_ready SHALL be 0; an already-registered output SHALL still drain normally.
REQ-029 The illegal word that causes the halt SHALL still be registered and presented on the output.
REQ-030 If clear and an illegal accept occur in the same cycle, clear SHALL win: err_count=0, err_sticky=0, state RUN.
REQ-031 clear SHALL NOT affect out_valid, out_bits or out_legal.

Reset
REQ-032 On reset: out_valid=0, out_bits=7'h00, out_legal=0, err_count=0, err_sticky=0, state=RUN (halted=0); in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard any pending output word with no handshake.

Verification
REQ-034 Stream 00,01,02,64,65 with out_ready=1 -> same values out, one cycle later, back-to-back; out_legal=1 each; err_count=0.
REQ-035 SAFE_CAST=1, inputs 03,63,7F -> out_bits=00, out_legal=0 each; err_count=3; err_sticky=1.
REQ-036 out_ready=0 for 4 cycles holding 64 -> out_bits=64 stable, in_ready=0; release -> 64 transferred once.
REQ-037 HALT_ON_ERROR=1, inputs 01,05,02 -> 01 and 05 output, halted=1, in_ready=0, 02 not accepted; clear pulse -> RUN, 02 accepted, err_count=0.
REQ-038 CNT_W=2, 5 illegal codes -> err_count saturates at 3.
REQ-039 Reset while out_valid=1 with out_ready=0 -> next cycle out_valid=0, all counters 0, in_ready=1.
